// File: rtl/fifo_rd_stream.sv
// Read-side adapter for a non-FWFT FIFO. It prefetches against a credit limit so that
// returning data always has a free skid-buffer slot, and it frames the output stream into fixed-length packets.
module fifo_rd_stream #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BUF_DEPTH = 3,
    parameter int unsigned PKT_LEN   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             fifo_read,
    input  logic [WIDTH-1:0]                 fifo_dout,
    input  logic                             fifo_empty,
    output logic [WIDTH-1:0]                 m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_last,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                      pkt_cnt
);

    localparam int unsigned OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned PKT_W  = 16;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $fatal(1, "fifo_rd_stream: RD_LAT must be 1 or 2");
    end
    if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
        $fatal(1, "fifo_rd_stream: BUF_DEPTH must be at least RD_LAT+1");
    end
    if (PKT_LEN < 1) begin : g_bad_pkt
        $fatal(1, "fifo_rd_stream: PKT_LEN must be at least 1");
    end

    logic [WIDTH-1:0]  mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  infl_q, infl_d;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [PKT_W-1:0]  pkt_q, pkt_d;
    logic [OCC_W:0]    credit;
    logic              capture;
    logic              pop;

    // Next-state logic: credit-gated read issue, return pipe, buffer pointers and framing.
    always_comb begin
        m_valid   = (occ_q != '0);
        m_data    = mem_q[head_q];
        m_last    = m_valid && (beat_q == BEAT_W'(PKT_LEN - 1));
        occupancy = occ_q;
        pkt_cnt   = pkt_q;

        // A pop in this cycle is deliberately not counted as freed space.
        credit    = {1'b0, occ_q} + {1'b0, infl_q};
        fifo_read = !rst && !fifo_empty && (credit < (OCC_W + 1)'(BUF_DEPTH));

        capture   = rd_pipe_q[RD_LAT-1];
        pop       = m_valid && m_ready;

        rd_pipe_d    = rd_pipe_q;
        rd_pipe_d[0] = fifo_read;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        infl_d = infl_q;
        unique case ({fifo_read, capture})
            2'b10:   infl_d = infl_q + OCC_W'(1);
            2'b01:   infl_d = infl_q - OCC_W'(1);
            default: infl_d = infl_q;
        endcase

        occ_d = occ_q;
        unique case ({capture, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        head_d = head_q;
        if (pop) begin
            head_d = (head_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
        end
        tail_d = tail_q;
        if (capture) begin
            tail_d = (tail_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
        end

        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (pop) begin
            beat_d = m_last ? '0 : beat_q + BEAT_W'(1);
            if (m_last) begin
                pkt_d = pkt_q + PKT_W'(1);
            end
        end
    end

    // Control registers; in-flight reads are forgotten on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q     <= '0;
            infl_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rd_pipe_q <= '0;
            beat_q    <= '0;
            pkt_q     <= '0;
        end else begin
            assert (!(capture && !pop && occ_q == OCC_W'(BUF_DEPTH)))
                else $error("fifo_rd_stream: skid buffer overflow");
            occ_q     <= occ_d;
            infl_q    <= infl_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rd_pipe_q <= rd_pipe_d;
            beat_q    <= beat_d;
            pkt_q     <= pkt_d;
        end
    end

    // Data storage carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            mem_q[tail_q] <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream. Three instances (lat1/d3, lat2/d3, lat2/d4) share the same stimulus,
// and each instance has its own FIFO read-port model.
module tb_fifo_rd_stream;

    localparam int NI  = 3;
    localparam int PKT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_ready;
    int          wp;
    logic [15:0] mem [256];

    logic        f_read    [NI];
    logic        fe_w      [NI];
    logic        m_valid_w [NI];
    logic        m_last_w  [NI];
    logic [15:0] dout_w    [NI];
    logic [15:0] m_data_w  [NI];
    logic [15:0] pkt_w     [NI];
    logic [2:0]  occ_w     [NI];
    int          rp_w      [NI];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    function automatic int lat_of(int g); return (g == 0) ? 1 : 2; endfunction
    function automatic int dep_of(int g); return (g == 2) ? 4 : 3; endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 2;
        localparam int unsigned DEP = (g == 2) ? 4 : 3;
        int          rp = 0;
        logic [15:0] d1 = '0;
        logic [15:0] d2 = '0;
        logic [$clog2(DEP+1)-1:0] occ_l;

        // Non-FWFT read port: output register loads on a read, optional second output stage.
        always @(posedge clk) begin
            if (rst) rp <= 0;
            else if (f_read[g]) begin
                rp <= rp + 1;
                d1 <= mem[8'(rp)];
            end
            d2 <= d1;
        end
        assign rp_w[g]   = rp;
        assign fe_w[g]   = (rp >= wp);
        assign dout_w[g] = (LAT == 1) ? d1 : d2;
        assign occ_w[g]  = 3'(occ_l);

        fifo_rd_stream #(.WIDTH(16), .RD_LAT(LAT), .BUF_DEPTH(DEP), .PKT_LEN(PKT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .fifo_read (f_read[g]),
            .fifo_dout (dout_w[g]),
            .fifo_empty(fe_w[g]),
            .m_data    (m_data_w[g]),
            .m_valid   (m_valid_w[g]),
            .m_ready   (m_ready),
            .m_last    (m_last_w[g]),
            .occupancy (occ_l),
            .pkt_cnt   (pkt_w[g])
        );
    end

    // Model: words in the buffer, reads still travelling with their remaining latency, beat totals.
    logic [15:0] buf_q  [NI][$];
    int          pend_t [NI][$];
    logic [15:0] pend_d [NI][$];
    logic [15:0] last_q [NI][$];
    int          beats  [NI];
    int          n_hs   [NI];
    int          first_hs [NI];
    int          last_hs  [NI];
    int          peak   [NI];
    bit          exp_read  [NI];
    bit          exp_valid [NI];

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cyc %0d: got %0h want %0h", nm, g, cyc_n, act, exp);
        end
    endtask

    task automatic model_cmp();
        for (int g = 0; g < NI; g++) begin
            int occ;
            bit v;
            bit er;
            occ = buf_q[g].size();
            v   = (occ != 0);
            er  = !rst && !fe_w[g] && ((occ + pend_t[g].size()) < dep_of(g));
            exp_read[g]  = er;
            exp_valid[g] = v;
            chk("fifo_read", g, 32'(f_read[g]), 32'(er));
            chk("m_valid", g, 32'(m_valid_w[g]), 32'(v));
            chk("occupancy", g, 32'(occ_w[g]), 32'(occ));
            chk("pkt_cnt", g, 32'(pkt_w[g]), 32'(16'(beats[g] / PKT)));
            chk("m_last", g, 32'(m_last_w[g]), 32'(v && (beats[g] % PKT == PKT - 1)));
            if (v) chk("m_data", g, 32'(m_data_w[g]), 32'(buf_q[g][0]));
            if (int'(occ_w[g]) > peak[g]) peak[g] = int'(occ_w[g]);
        end
    endtask

    task automatic model_update();
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                buf_q[g].delete();
                pend_t[g].delete();
                pend_d[g].delete();
                last_q[g].delete();
                beats[g] = 0;
                n_hs[g]  = 0;
                peak[g]  = 0;
            end else begin
                if (exp_valid[g] && m_ready) begin
                    if (beats[g] % PKT == PKT - 1) last_q[g].push_back(buf_q[g][0]);
                    buf_q[g].delete(0);
                    if (n_hs[g] == 0) first_hs[g] = cyc_n;
                    last_hs[g] = cyc_n;
                    n_hs[g]++;
                    beats[g]++;
                end
                for (int i = 0; i < pend_t[g].size(); i++) pend_t[g][i] = pend_t[g][i] - 1;
                while (pend_t[g].size() > 0 && pend_t[g][0] == 0) begin
                    buf_q[g].push_back(pend_d[g][0]);
                    pend_d[g].delete(0);
                    pend_t[g].delete(0);
                end
                if (exp_read[g]) begin
                    pend_t[g].push_back(lat_of(g));
                    pend_d[g].push_back(mem[8'(rp_w[g])]);
                end
            end
        end
    endtask

    task automatic cycle_mid(); @(negedge clk); model_cmp(); endtask
    task automatic cycle_end(); model_update(); @(posedge clk); #1; cyc_n++; endtask
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin cycle_mid(); cycle_end(); end
    endtask

    task automatic load(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            mem[8'(wp)] = base + 16'(i);
            wp++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wp  = 0;
        cycle_mid();
        for (int g = 0; g < NI; g++) chk("rst_read", g, 32'(f_read[g]), 32'(0));
        cycle_end();
        rst = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            beats[g] = 0; n_hs[g] = 0; peak[g] = 0; first_hs[g] = 0; last_hs[g] = 0;
        end
        rst = 1'b1; m_ready = 1'b0; wp = 0;

        // Reset held three edges with data available.
        load(4, 16'h1000);
        #1;
        for (int g = 0; g < NI; g++) chk("rst_read0", g, 32'(f_read[g]), 32'(0));
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            cycle_mid();
            for (int g = 0; g < NI; g++) chk("rst_read", g, 32'(f_read[g]), 32'(0));
            cycle_end();
        end
        rst = 1'b0;
        cycle_mid();
        for (int g = 0; g < NI; g++) begin
            chk("post_rst_valid", g, 32'(m_valid_w[g]), 32'(0));
            chk("post_rst_occ", g, 32'(occ_w[g]), 32'(0));
            chk("post_rst_pkt", g, 32'(pkt_w[g]), 32'(0));
        end
        cycle_end();
        m_ready = 1'b1;
        step(10);

        // Single word, latency 1 timing on instance 0.
        load(1, 16'hA5A5);
        cycle_mid();
        for (int g = 0; g < NI; g++) chk("single_read", g, 32'(f_read[g]), 32'(1));
        cycle_end();
        cycle_mid(); chk("single_c1_valid", 0, 32'(m_valid_w[0]), 32'(0)); cycle_end();
        cycle_mid();
        chk("single_c2_valid", 0, 32'(m_valid_w[0]), 32'(1));
        chk("single_c2_data", 0, 32'(m_data_w[0]), 32'h0000_A5A5);
        chk("single_c2_last", 0, 32'(m_last_w[0]), 32'(0));
        cycle_end();
        cycle_mid();
        chk("single_c3_read", 0, 32'(f_read[0]), 32'(0));
        chk("single_c3_valid", 0, 32'(m_valid_w[0]), 32'(0));
        cycle_end();
        step(4);

        // Streaming 32 words.
        do_reset();
        load(32, 16'h0000);
        step(70);
        for (int g = 0; g < NI; g++) begin
            chk("stream_pkt", g, 32'(pkt_w[g]), 32'(4));
            chk("stream_hs", g, 32'(n_hs[g]), 32'(32));
        end
        chk("stream_span", 0, 32'(last_hs[0] - first_hs[0]), 32'(31));
        chk("stream_span", 2, 32'(last_hs[2] - first_hs[2]), 32'(31));
        chk("last_count", 0, 32'(last_q[0].size()), 32'(4));
        for (int i = 0; i < 4 && i < last_q[0].size(); i++)
            chk("last_word", 0, 32'(last_q[0][i]), 32'(8 * i + 7));

        // Backpressure: ten cycles of m_ready=0 starting in cycle 4.
        do_reset();
        load(20, 16'd100);
        step(4);
        m_ready = 1'b0;
        step(9);
        cycle_mid();
        chk("bp_head", 1, 32'(m_data_w[1]), 32'd101);
        chk("bp_occ", 1, 32'(occ_w[1]), 32'(3));
        chk("bp_read", 1, 32'(f_read[1]), 32'(0));
        cycle_end();
        chk("bp_peak", 1, 32'(peak[1]), 32'(3));
        m_ready = 1'b1;
        step(40);
        for (int g = 0; g < NI; g++) chk("bp_hs", g, 32'(n_hs[g]), 32'(20));

        // Empty bubble after six words.
        do_reset();
        load(6, 16'd200);
        step(12);
        cycle_mid();
        for (int g = 0; g < NI; g++) begin
            chk("bubble_valid", g, 32'(m_valid_w[g]), 32'(0));
            chk("bubble_pkt", g, 32'(pkt_w[g]), 32'(0));
        end
        cycle_end();
        load(10, 16'd206);
        step(30);
        for (int g = 0; g < NI; g++) chk("bubble_pkt2", g, 32'(pkt_w[g]), 32'(2));
        chk("bubble_lastn", 0, 32'(last_q[0].size()), 32'(2));
        if (last_q[0].size() >= 2) begin
            chk("bubble_last0", 0, 32'(last_q[0][0]), 32'd207);
            chk("bubble_last1", 0, 32'(last_q[0][1]), 32'd215);
        end

        // Reset in the middle of a burst, then refill.
        do_reset();
        load(32, 16'h0000);
        step(10);
        rst = 1'b1; wp = 0;
        cycle_mid();
        for (int g = 0; g < NI; g++) chk("mid_rst_read", g, 32'(f_read[g]), 32'(0));
        cycle_end();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle_mid();
            for (int g = 0; g < NI; g++) begin
                chk("mid_rst_valid", g, 32'(m_valid_w[g]), 32'(0));
                chk("mid_rst_occ", g, 32'(occ_w[g]), 32'(0));
            end
            cycle_end();
        end
        load(16, 16'd300);
        step(40);
        for (int g = 0; g < NI; g++) begin
            chk("refill_pkt", g, 32'(pkt_w[g]), 32'(2));
            chk("refill_hs", g, 32'(n_hs[g]), 32'(16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
